counter_bcd_updown: RTL and testbench

//  Parametrised BCD up/down counter for the stopwatch/timer datapath. A prescaler

---
 rtl/counter_bcd_updown_pkg.sv | 13 +
 rtl/counter_bcd_updown_digit.sv | 37 +++
 rtl/counter_bcd_updown.sv | 102 ++++++++++
 tb/tb_counter_bcd_updown.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bcd_updown_pkg.sv
// Shared BCD digit type, digit limits and load saturation helper for the BCD counter.
package counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

    function automatic bcd_t bcd_sat(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/counter_bcd_updown_digit.sv
// Single BCD digit cell: clear > load > count, rolls 9->0 up and 0->9 down.
import counter_pkg::*;

module bcd_digit (
    input  logic clk,
    input  logic reset_p,
    input  logic en,
    input  logic down,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic clr,
    output bcd_t q,
    output logic at_max,
    output logic at_min
);

    bcd_t r_q;

    always_ff @(posedge clk) begin
        if (reset_p || clr) begin
            r_q <= BCD_ZERO;
        end else if (ld) begin
            r_q <= bcd_sat(ld_val);
        end else if (en) begin
            if (down) begin
                r_q <= (r_q == BCD_ZERO) ? BCD_MAX : r_q - 4'd1;
            end else begin
                r_q <= (r_q >= BCD_MAX) ? BCD_ZERO : r_q + 4'd1;
            end
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == BCD_MAX);
    assign at_min = (r_q == BCD_ZERO);

endmodule

// File: rtl/counter_bcd_updown.sv
// BCD up/down counter: tick prescaler, DIGITS-wide digit chain, wrap detect, lap register.
import counter_pkg::*;

module counter_bcd_updown #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic                  tick_in,
    input  logic                  run,
    input  logic                  down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  lap_req,
    input  logic                  lap_show,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [4*DIGITS-1:0]   live_val,
    output logic                  step_p,
    output logic                  wrap_p
);

    localparam int unsigned PW = $clog2(TICK_DIV + 1);

    logic [PW-1:0]         r_pre;
    logic [4*DIGITS-1:0]   r_lap;
    logic                  r_step_p;
    logic                  r_wrap_p;

    logic                  w_tick;
    logic                  w_pre_term;
    logic                  w_step;
    logic                  w_wrap;
    logic [DIGITS:0]       w_lo_max;
    logic [DIGITS:0]       w_lo_min;
    logic [DIGITS-1:0]     w_at_max;
    logic [DIGITS-1:0]     w_at_min;
    logic [DIGITS-1:0]     w_en;
    bcd_t                  w_q [DIGITS];

    assign w_tick     = run & tick_in;
    assign w_pre_term = (r_pre == PW'(TICK_DIV - 1));
    // clear/load pre-empt a step in the same cycle, so no step/wrap pulse is reported
    assign w_step     = w_tick & w_pre_term & ~clear & ~load;

    always_ff @(posedge clk) begin
        if (reset_p || clear || load) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= w_pre_term ? '0 : r_pre + PW'(1);
        end
    end

    assign w_lo_max[0] = 1'b1;
    assign w_lo_min[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_lo_max[gi+1] = w_lo_max[gi] & w_at_max[gi];
            assign w_lo_min[gi+1] = w_lo_min[gi] & w_at_min[gi];
            assign w_en[gi]       = w_step & (down ? w_lo_min[gi] : w_lo_max[gi]);

            bcd_digit u_digit (
                .clk     (clk),
                .reset_p (reset_p),
                .en      (w_en[gi]),
                .down    (down),
                .ld      (load),
                .ld_val  (load_val[4*gi +: 4]),
                .clr     (clear),
                .q       (w_q[gi]),
                .at_max  (w_at_max[gi]),
                .at_min  (w_at_min[gi])
            );

            assign live_val[4*gi +: 4] = w_q[gi];
        end
    endgenerate

    assign w_wrap = w_step & (down ? w_lo_min[DIGITS] : w_lo_max[DIGITS]);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_step_p <= 1'b0;
            r_wrap_p <= 1'b0;
            r_lap    <= '0;
        end else begin
            r_step_p <= w_step;
            r_wrap_p <= w_wrap;
            if (lap_req) begin
                r_lap <= live_val;
            end
        end
    end

    assign step_p    = r_step_p;
    assign wrap_p    = r_wrap_p;
    assign value_out = lap_show ? r_lap : live_val;

endmodule

// File: tb/tb_counter_bcd_updown.sv
// Directed bench: DIGITS=2/TICK_DIV=3 instance for main features, DIGITS=4/TICK_DIV=1 for long wrap.
module tb_counter_bcd_updown;

    logic        clk = 1'b0;
    logic        reset_p = 1'b0;
    logic        tick_in = 1'b0, run = 1'b0, down = 1'b0, clear = 1'b0, load = 1'b0;
    logic [7:0]  load_val = '0;
    logic        lap_req = 1'b0, lap_show = 1'b0;
    logic [7:0]  value_out, live_val;
    logic        step_p, wrap_p;

    logic        tick2 = 1'b0, run2 = 1'b0, down2 = 1'b0;
    logic [15:0] value2, live2;
    logic        step2, wrap2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_bcd_updown #(.DIGITS(2), .TICK_DIV(3)) dut (
        .clk(clk), .reset_p(reset_p), .tick_in(tick_in), .run(run), .down(down),
        .clear(clear), .load(load), .load_val(load_val), .lap_req(lap_req),
        .lap_show(lap_show), .value_out(value_out), .live_val(live_val),
        .step_p(step_p), .wrap_p(wrap_p)
    );

    counter_bcd_updown #(.DIGITS(4), .TICK_DIV(1)) dut4 (
        .clk(clk), .reset_p(reset_p), .tick_in(tick2), .run(run2), .down(down2),
        .clear(1'b0), .load(1'b0), .load_val(16'h0000), .lap_req(1'b0),
        .lap_show(1'b0), .value_out(value2), .live_val(live2),
        .step_p(step2), .wrap_p(wrap2)
    );

    // Stimulus helpers: enter and leave on a falling edge
    task automatic do_tick(output logic s, output logic w);
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
        s = step_p;
        w = wrap_p;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        n_tests++;
        if (live_val !== 8'h00) begin n_fail++; $display("FAIL reset_live: got %h expected 00", live_val); end
        n_tests++;
        if (value_out !== 8'h00) begin n_fail++; $display("FAIL reset_value: got %h expected 00", value_out); end
        n_tests++;
        if ({step_p, wrap_p} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {step_p, wrap_p}); end
    endtask

    task automatic test_count_up;
        logic s, w;
        run = 1'b1;
        down = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            do_tick(s, w);
            n_tests++;
            if (s !== ((t % 3) == 0)) begin n_fail++; $display("FAIL up_step_t%0d: got %b expected %b", t, s, (t % 3) == 0); end
        end
        n_tests++;
        if (live_val !== 8'h02) begin n_fail++; $display("FAIL up_live: got %h expected 02", live_val); end
        n_tests++;
        if (step_p !== 1'b0) begin n_fail++; $display("FAIL up_step_width: got %b expected 0", step_p); end
    endtask

    task automatic test_wrap_up;
        logic s, w;
        do_load(8'h98);
        n_tests++;
        if (live_val !== 8'h98) begin n_fail++; $display("FAIL load98: got %h expected 98", live_val); end
        for (int t = 1; t <= 6; t++) begin
            do_tick(s, w);
            n_tests++;
            if (w !== (t == 6)) begin n_fail++; $display("FAIL upwrap_t%0d: got %b expected %b", t, w, t == 6); end
            if (t == 3) begin
                n_tests++;
                if (live_val !== 8'h99) begin n_fail++; $display("FAIL up_99: got %h expected 99", live_val); end
            end
        end
        n_tests++;
        if (live_val !== 8'h00) begin n_fail++; $display("FAIL upwrap_live: got %h expected 00", live_val); end
    endtask

    task automatic test_wrap_down;
        logic s, w;
        down = 1'b1;
        do_load(8'h01);
        for (int t = 1; t <= 6; t++) begin
            do_tick(s, w);
            n_tests++;
            if (w !== (t == 6)) begin n_fail++; $display("FAIL dnwrap_t%0d: got %b expected %b", t, w, t == 6); end
            if (t == 3) begin
                n_tests++;
                if (live_val !== 8'h00) begin n_fail++; $display("FAIL dn_00: got %h expected 00", live_val); end
            end
        end
        n_tests++;
        if (live_val !== 8'h99) begin n_fail++; $display("FAIL dnwrap_live: got %h expected 99", live_val); end
        down = 1'b0;
    endtask

    task automatic test_load_clear;
        logic s, w;
        do_load(8'hAF);
        n_tests++;
        if (live_val !== 8'h99) begin n_fail++; $display("FAIL load_sat: got %h expected 99", live_val); end
        do_tick(s, w);
        clear = 1'b1;
        load = 1'b1;
        load_val = 8'h55;
        @(negedge clk);
        clear = 1'b0;
        load = 1'b0;
        n_tests++;
        if (live_val !== 8'h00) begin n_fail++; $display("FAIL clear_wins: got %h expected 00", live_val); end
        for (int t = 1; t <= 3; t++) begin
            do_tick(s, w);
            n_tests++;
            if (s !== (t == 3)) begin n_fail++; $display("FAIL clr_pre_t%0d: got %b expected %b", t, s, t == 3); end
        end
        n_tests++;
        if (live_val !== 8'h01) begin n_fail++; $display("FAIL clr_pre_live: got %h expected 01", live_val); end
    endtask

    task automatic test_lap;
        logic s, w;
        do_load(8'h25);
        lap_req = 1'b1;
        @(negedge clk);
        lap_req = 1'b0;
        lap_show = 1'b1;
        for (int t = 1; t <= 9; t++) do_tick(s, w);
        n_tests++;
        if (value_out !== 8'h25) begin n_fail++; $display("FAIL lap_show: got %h expected 25", value_out); end
        n_tests++;
        if (live_val !== 8'h28) begin n_fail++; $display("FAIL lap_live: got %h expected 28", live_val); end
        lap_show = 1'b0;
        #1;
        n_tests++;
        if (value_out !== 8'h28) begin n_fail++; $display("FAIL lap_hide: got %h expected 28", value_out); end
        @(negedge clk);
        do_tick(s, w);
        do_tick(s, w);
        tick_in = 1'b1;
        lap_req = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
        lap_req = 1'b0;
        n_tests++;
        if ({step_p, live_val} !== {1'b1, 8'h29}) begin n_fail++; $display("FAIL lap_step_live: got %b/%h expected 1/29", step_p, live_val); end
        lap_show = 1'b1;
        #1;
        n_tests++;
        if (value_out !== 8'h28) begin n_fail++; $display("FAIL lap_prestep: got %h expected 28", value_out); end
        lap_show = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run_hold;
        logic s, w;
        int nsteps;
        nsteps = 0;
        run = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            do_tick(s, w);
            nsteps += int'(s);
        end
        n_tests++;
        if (nsteps != 0) begin n_fail++; $display("FAIL hold_steps: got %0d expected 0", nsteps); end
        n_tests++;
        if (live_val !== 8'h29) begin n_fail++; $display("FAIL hold_live: got %h expected 29", live_val); end
        run = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic s, w;
        do_tick(s, w);
        do_tick(s, w);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        do_tick(s, w);
        n_tests++;
        if (s !== 1'b0) begin n_fail++; $display("FAIL rst_mid_step: got %b expected 0", s); end
        n_tests++;
        if (live_val !== 8'h00) begin n_fail++; $display("FAIL rst_mid_live: got %h expected 00", live_val); end
        lap_show = 1'b1;
        #1;
        n_tests++;
        if (value_out !== 8'h00) begin n_fail++; $display("FAIL rst_lap: got %h expected 00", value_out); end
        lap_show = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic test_back_to_back;
        int nsteps, nwraps;
        nsteps = 0;
        nwraps = 0;
        run2 = 1'b1;
        down2 = 1'b0;
        tick2 = 1'b1;
        for (int k = 1; k <= 10000; k++) begin
            @(negedge clk);
            nsteps += int'(step2);
            nwraps += int'(wrap2);
            if (k == 1234 || k == 9999) begin
                n_tests++;
                if (live2 !== to_bcd4(k)) begin n_fail++; $display("FAIL wide_k%0d: got %h expected %h", k, live2, to_bcd4(k)); end
            end
        end
        tick2 = 1'b0;
        n_tests++;
        if (nwraps != 1) begin n_fail++; $display("FAIL wide_wraps: got %0d expected 1", nwraps); end
        n_tests++;
        if (nsteps != 10000) begin n_fail++; $display("FAIL wide_steps: got %0d expected 10000", nsteps); end
        n_tests++;
        if (live2 !== 16'h0000) begin n_fail++; $display("FAIL wide_live: got %h expected 0000", live2); end
        down2 = 1'b1;
        tick2 = 1'b1;
        @(negedge clk);
        tick2 = 1'b0;
        n_tests++;
        if ({wrap2, value2} !== {1'b1, 16'h9999}) begin n_fail++; $display("FAIL wide_down: got %b/%h expected 1/9999", wrap2, value2); end
        @(negedge clk);
        n_tests++;
        if (wrap2 !== 1'b0) begin n_fail++; $display("FAIL wide_wrap_width: got %b expected 0", wrap2); end
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_wrap_up;
        test_wrap_down;
        test_load_clear;
        test_lap;
        test_run_hold;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
